// File: rtl/crossbar_pkg.sv
// Shared definitions for the crossbar port protocol and target responders.
package crossbar_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    localparam logic CMD_READ  = 1'b0;
    localparam logic CMD_WRITE = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ACK  = 2'd2,
        HOLD = 2'd3
    } resp_state_t;

endpackage

// File: rtl/crossbar_target_regfile.sv
// DEPTH x DATA_W word array: one synchronous write port, one registered read port.
module crossbar_target_regfile
    import crossbar_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [IDX_W-1:0]  idx,
    input  logic              we,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Array contents are deliberately not reset; software/bench initialises them.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[idx] <= wdata;
        end
    end

    // Read data is captured on the read strobe and then held until the next read.
    always_ff @(posedge clk) begin
        if (reset) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[idx];
        end
    end

endmodule

// File: rtl/crossbar_target_responder.sv
// Slave endpoint of one crossbar output column, backed by a word register array.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for req; captures addr/cmd/wdata and decodes on req=1
// WAIT  | wait-state countdown from WAIT_CYCLES-1 to 0, inputs ignored
// ACK   | single-cycle ack; array write or read strobe, or error response
// HOLD  | rdata held stable until initiator drops req
module crossbar_target_responder
    import crossbar_pkg::*;
#(
    parameter logic [ADDR_W-1:0] ADDR_BASE   = 32'h0000_0000,
    parameter int                DEPTH       = 16,
    parameter int                WAIT_CYCLES = 2,
    parameter logic [DATA_W-1:0] ERR_RDATA   = 32'hDEAD_BEEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req,
    input  logic [ADDR_W-1:0] addr,
    input  logic              cmd,
    input  logic [DATA_W-1:0] wdata,
    output logic              ack,
    output logic [DATA_W-1:0] rdata,
    output logic              busy,
    output logic              err
);

    localparam int           IDX_W     = $clog2(DEPTH);
    localparam logic [ADDR_W:0] WIN_BYTES = (ADDR_W+1)'(4 * DEPTH);
    localparam logic [3:0]   WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    resp_state_t       state;
    logic [3:0]        wait_cnt;
    logic              cmd_q;
    logic [DATA_W-1:0] wdata_q;
    logic              hit_q;
    logic [IDX_W-1:0]  idx_q;
    logic [DATA_W-1:0] rdata_q;
    logic              rd_sel;

    logic [ADDR_W:0]   offset;
    logic              dec_hit;
    logic [IDX_W-1:0]  dec_idx;

    logic              rf_we;
    logic              rf_re;
    logic [DATA_W-1:0] rf_rdata;

    // Window decode on the live address; one extra bit keeps base+size from wrapping.
    always_comb begin
        offset  = {1'b0, addr} - {1'b0, ADDR_BASE};
        dec_hit = (addr >= ADDR_BASE) && (offset < WIN_BYTES) && (addr[1:0] == 2'b00);
        dec_idx = offset[IDX_W+1:2];
    end

    // Main sequencer: capture, wait-state countdown, ack and hold handshake.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            wait_cnt <= '0;
            cmd_q    <= CMD_READ;
            wdata_q  <= '0;
            hit_q    <= 1'b0;
            idx_q    <= '0;
            rdata_q  <= '0;
            rd_sel   <= 1'b0;
            err      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req) begin
                        cmd_q    <= cmd;
                        wdata_q  <= wdata;
                        hit_q    <= dec_hit;
                        idx_q    <= dec_idx;
                        wait_cnt <= WAIT_LOAD;
                        state    <= (WAIT_CYCLES > 0) ? WAIT : ACK;
                    end
                end
                WAIT: begin
                    if (wait_cnt == 4'd0) begin
                        state <= ACK;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                ACK: begin
                    state <= HOLD;
                    if (!hit_q) begin
                        rdata_q <= ERR_RDATA;
                        err     <= 1'b1;
                    end else if (cmd_q == CMD_READ) begin
                        rd_sel <= 1'b1;
                    end
                end
                HOLD: begin
                    if (!req) begin
                        state   <= IDLE;
                        rdata_q <= '0;
                        rd_sel  <= 1'b0;
                    end
                end
                default: begin
                    state    <= IDLE;
                    wait_cnt <= '0;
                    rdata_q  <= '0;
                    rd_sel   <= 1'b0;
                end
            endcase
        end
    end

    // Array strobes fire only in ACK; reset in that same cycle suppresses the write.
    always_comb begin
        rf_we = (state == ACK) && hit_q && (cmd_q == CMD_WRITE) && !reset;
        rf_re = (state == ACK) && hit_q && (cmd_q == CMD_READ);
    end

    crossbar_target_regfile #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_regfile (
        .clk   (clk),
        .reset (reset),
        .idx   (idx_q),
        .we    (rf_we),
        .wdata (wdata_q),
        .re    (rf_re),
        .rdata (rf_rdata)
    );

    // Read hits present the array's registered output; everything else uses rdata_q.
    always_comb begin
        rdata = rd_sel ? rf_rdata : rdata_q;
        ack   = (state == ACK);
        busy  = (state == WAIT) || (state == ACK) || (state == HOLD);
    end

endmodule

// File: doc/crossbar_target_responder.md
Name: crossbar_target_responder

Overview:
- Slave-side endpoint of the crossbar port protocol (req/addr/cmd/wdata in; ack/rdata out). It terminates one crossbar output column.
- Backed by a word-addressed register array with a configurable decode window and programmable wait states.
- Used as the memory/peripheral model behind each crossbar output and as the template for real targets.

Parameters:
- ADDR_BASE, 32'h0000_0000, byte address of word 0 of the window
- DEPTH, 16, number of 32-bit words (power of two, 2..256)
- WAIT_CYCLES, 2, cycles between req capture and ack (0..15)
- ERR_RDATA, 32'hDEAD_BEEF, rdata returned on a decode error

Ports:
- clk  input  1  clock; all logic on rising edge
- reset  input  1  synchronous, active-high reset
- req  input  1  transaction request; initiator holds it high until the transaction ends
- addr  input  32  byte address; sampled at capture
- cmd  input  1  1 = write, 0 = read; sampled at capture
- wdata  input  32  write data; sampled at capture
- ack  output  1  single-cycle acknowledge
- rdata  output  32  read data
- busy  output  1  high whenever the FSM is not in IDLE
- err  output  1  sticky decode-error flag; cleared only by reset

Behaviour:
- Reset: FSM goes to IDLE; ack=0, rdata=0, busy=0, err=0, wait counter=0. Array contents are not reset (bench initialises them via writes).
- Reset asserted mid-transaction aborts it: no array write occurs unless the ACK cycle already completed.
- IDLE: when req=1, capture addr/cmd/wdata into holding registers and evaluate decode. Next state is WAIT if WAIT_CYCLES>0, else ACK.
- Decode hit condition: ADDR_BASE <= addr < ADDR_BASE+4*DEPTH and addr[1:0]==0. Word index = (addr-ADDR_BASE)>>2, truncated to log2(DEPTH) bits.
- WAIT: counter runs from WAIT_CYCLES-1 down to 0; go to ACK when the counter reaches 0. req is not re-sampled; captured values are used.
- ACK (exactly one cycle):
  - ack=1.
  - Write hit: array[index] <= captured wdata at this edge.
  - Read hit: rdata <= array[index], registered, valid on the cycle after ACK.
  - Any miss: no array update; rdata <= ERR_RDATA; err <= 1.
  - Next state: HOLD.
- Latency from req sampled high to ack high = WAIT_CYCLES+1 cycles.
- HOLD:
  - ack=0.
  - rdata is held stable from the cycle after ACK until HOLD exits. The initiator forwards it two cycles after ack.
  - Stay in HOLD while req=1. When req=0, go to IDLE and clear rdata to 0 on that transition.
  - A new transaction can be captured only after at least one IDLE cycle with req=0. Back-to-back requests are never merged.
- Write transactions leave rdata at 0 throughout.
- Changes on addr/cmd/wdata after capture are ignored.
- busy=1 in WAIT, ACK and HOLD.
- Illegal state encodings recover to IDLE with all outputs 0.

Decomposition:
- Shared package crossbar_pkg holds:
  - ADDR_W=32, DATA_W=32
  - CMD_READ=1'b0, CMD_WRITE=1'b1
  - state typedef resp_state_t {IDLE, WAIT, ACK, HOLD}
- One natural sub-module: crossbar_target_regfile. It is the DEPTH x 32 array with a single synchronous write port and a registered read port.
- FSM, decode and wait counter live in the top module.

Test Plan:
- Write then read (WAIT_CYCLES=2, ADDR_BASE=0): req write addr 0x8 wdata 0xA5A5_1234. ack pulses exactly 3 cycles after req is sampled. After req drops, a read at 0x8 returns rdata=0xA5A5_1234, held until req falls.
- Zero wait (WAIT_CYCLES=0): read at 0x0 after writing 0x1 gives ack on the cycle after capture; rdata=0x1 on the following cycle.
- Decode miss: read at ADDR_BASE+4*DEPTH (0x40 for defaults) and at misaligned 0x2. Each gives an ack, rdata=0xDEAD_BEEF and err=1 (sticky); array unchanged, and re-reading 0x0 returns its prior value.
- Held req: keep req high 10 cycles after ack. Only one ack pulse occurs, busy stays 1, and no second transaction starts until req=0 for one cycle.
- Input churn: change addr/wdata to 0xFFFF_FFFF during WAIT. Write lands at the originally captured address with the captured data.
- Reset mid-WAIT of a write to 0x4 (prior contents 0x0): ack never asserts, outputs go to 0 the next cycle, and a subsequent read of 0x4 returns 0x0.
